// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: arbitrates CPU fetch and data channels onto one synchronous SRAM
// with optional wait states and registered, backpressure-stable responses.
module cpu_mem_bridge #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ready,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ready,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  input  logic                  MemRead,
  output logic                  Mem_Req_Ready,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  output logic [3:0]            mem_wen,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           mem_busy_cnt
);
  typedef enum logic [2:0] {IDLE, WAIT, ACC, CAP, IRESP, DRESP} state_t;
  typedef enum logic [1:0] {K_IF, K_LD, K_ST} kind_t;
  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);
  state_t state, nxt;
  kind_t kind;
  logic [ADDR_WIDTH-1:0] addr_q, last_addr;
  logic [31:0] wdata_q, last_wdata, resp;
  logic [3:0] strb_q, cnt;
  logic take_d, take_i, acc_st;
  assign take_d = state == IDLE && (MemRead || MemWrite);
  assign take_i = state == IDLE && Inst_Req_Valid && !MemRead && !MemWrite;
  assign acc_st = state == ACC && kind == K_ST;
  assign Mem_Req_Ready = state == IDLE;
  assign Inst_Req_Ready = state == IDLE && !MemRead && !MemWrite;
  assign Inst_Valid = state == IRESP;
  assign Read_data_Valid = state == DRESP;
  assign Instruction = resp;
  assign Read_data = resp;
  // the rst gate keeps a store caught in ACC from writing during the reset cycle
  assign mem_ren = state == ACC && kind != K_ST && !rst;
  assign mem_wen = (acc_st && !rst) ? strb_q : 4'b0000;
  assign mem_addr = state == ACC ? addr_q : last_addr;
  assign mem_wdata = acc_st ? wdata_q : last_wdata;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = (take_d || take_i) ? (WAIT_CYCLES > 0 ? WAIT : ACC) : IDLE;
      WAIT:  nxt = cnt == WLAST ? ACC : WAIT;
      ACC:   nxt = kind == K_ST ? IDLE : CAP;
      CAP:   nxt = kind == K_IF ? IRESP : DRESP;
      IRESP: nxt = Inst_Ready ? IDLE : IRESP;
      DRESP: nxt = Read_data_Ready ? IDLE : DRESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kind <= K_IF;
      cnt <= '0;
      resp <= '0;
      mem_busy_cnt <= '0;
      addr_q <= '0;
      last_addr <= '0;
      wdata_q <= '0;
      last_wdata <= '0;
      strb_q <= '0;
    end else begin
      state <= nxt;
      mem_busy_cnt <= mem_busy_cnt + 32'(state != IDLE);
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
      if (take_d || take_i) begin
        kind <= take_d ? (MemWrite ? K_ST : K_LD) : K_IF;
        addr_q <= take_d ? Address[ADDR_WIDTH+1:2] : PC[ADDR_WIDTH+1:2];
        wdata_q <= Write_data;
        strb_q <= Write_strb;
      end
      if (state == ACC) last_addr <= addr_q;
      if (acc_st) last_wdata <= wdata_q;
      if (state == CAP) resp <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: scoreboard bench; stimulus queues expected SRAM accesses and
// responses, a monitor pops and compares them as the DUT presents them.
module tb_cpu_mem_bridge;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_fail = 0;

  logic [31:0] PC = 0, Address = 0, Write_data = 0, mem_rdata = 0;
  logic Inst_Req_Valid = 0, Inst_Ready = 1, MemWrite = 0, MemRead = 0, Read_data_Ready = 1;
  logic [3:0] Write_strb = 0;
  logic Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid, mem_ren;
  logic [31:0] Instruction, Read_data, mem_wdata, mem_busy_cnt;
  logic [15:0] mem_addr;
  logic [3:0] mem_wen;

  cpu_mem_bridge #(.ADDR_WIDTH(16), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Address(Address),
    .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb), .MemRead(MemRead),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy_cnt(mem_busy_cnt));

  // second instance with three wait states for latency and reset-abort checks
  logic w_rst = 1, w_ivalid = 0, w_mw = 0;
  logic [31:0] w_pc = 0, w_addr = 0, w_rdata = 0;
  logic w_irr, w_iv, w_mrr, w_rv, w_ren;
  logic [31:0] w_inst, w_rd, w_wdata, w_busy;
  logic [15:0] w_mem_addr;
  logic [3:0] w_wen;
  int w_wen_cnt = 0;

  cpu_mem_bridge #(.ADDR_WIDTH(16), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(w_rst), .PC(w_pc), .Inst_Req_Valid(w_ivalid), .Inst_Req_Ready(w_irr),
    .Instruction(w_inst), .Inst_Valid(w_iv), .Inst_Ready(1'b1), .Address(w_addr),
    .MemWrite(w_mw), .Write_data(32'h12345678), .Write_strb(4'hF), .MemRead(1'b0),
    .Mem_Req_Ready(w_mrr), .Read_data(w_rd), .Read_data_Valid(w_rv),
    .Read_data_Ready(1'b1), .mem_addr(w_mem_addr), .mem_ren(w_ren), .mem_wen(w_wen),
    .mem_wdata(w_wdata), .mem_rdata(w_rdata), .mem_busy_cnt(w_busy));

  always @(posedge clk) if (w_ren) w_rdata <= {16'hA5A5, w_mem_addr};
  always @(negedge clk) if (w_wen != 0) w_wen_cnt <= w_wen_cnt + 1;

  logic [31:0] sram [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
      sram[3] <= 32'h3C010001;
      sram[4] <= 32'hDEADBEEF;
      sram[8] <= 32'h11223344;
      sram[9] <= 32'h0BADF00D;
    end else begin
      if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) sram[mem_addr[7:0]][8*b+:8] <= mem_wdata[8*b+:8];
    end
  end

  // access entry: {ren, wen, addr, wdata, cycle}; response entry: {is_fetch, data, valid-rise cycle}
  logic [84:0] aq[$];
  logic [64:0] rq[$];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  logic vp = 0;
  int rc = 0;
  logic [31:0] rdq = 0;
  always begin
    logic v, rdy;
    logic [31:0] dat;
    logic [84:0] ea;
    logic [64:0] er;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (mem_ren || mem_wen != 0) begin
        if (aq.size() == 0) check("acc_unexpected", {mem_ren, mem_wen, mem_addr}, 0);
        else begin
          ea = aq.pop_front();
          check("acc", {mem_ren, mem_wen, mem_addr, (mem_wen != 0) ? mem_wdata : 32'h0, 32'(cyc)}, ea);
        end
      end
      check("ready_valid_excl", {Inst_Req_Ready & Inst_Valid, Mem_Req_Ready & Read_data_Valid}, 0);
      v = Inst_Valid | Read_data_Valid;
      dat = Inst_Valid ? Instruction : Read_data;
      rdy = Inst_Valid ? Inst_Ready : Read_data_Ready;
      if (v && vp) check("resp_stable", dat, rdq);
      if (v && !vp) begin rc = cyc; rdq = dat; end
      if (v && rdy) begin
        if (rq.size() == 0) check("resp_unexpected", dat, 0);
        else begin
          er = rq.pop_front();
          check("resp", {Inst_Valid, dat, 32'(rc)}, er);
        end
      end
      vp = v;
    end
  end

  task automatic issue_d(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp, output int hs);
    @(negedge clk);
    Address = a; MemRead = rd; MemWrite = wr; Write_data = wd; Write_strb = st;
    hs = -1;
    for (int i = 0; i < 40 && hs < 0; i++) begin
      #1;
      if (Mem_Req_Ready) hs = cyc;
      else @(negedge clk);
    end
    if (hs < 0) check("d_req_timeout", 0, 1);
    else begin
      aq.push_back({!wr, wr ? st : 4'h0, a[17:2], wr ? wd : 32'h0, 32'(hs + 1)});
      if (!wr) rq.push_back({1'b0, exp, 32'(hs + 3)});
    end
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0;
  endtask

  task automatic issue_f(input logic [31:0] pc, input logic [31:0] exp, output int hs);
    @(negedge clk);
    PC = pc; Inst_Req_Valid = 1;
    hs = -1;
    for (int i = 0; i < 40 && hs < 0; i++) begin
      #1;
      if (Inst_Req_Ready) hs = cyc;
      else @(negedge clk);
    end
    if (hs < 0) check("f_req_timeout", 0, 1);
    else begin
      aq.push_back({1'b1, 4'h0, pc[17:2], 32'h0, 32'(hs + 1)});
      rq.push_back({1'b1, exp, 32'(hs + 3)});
    end
    @(posedge clk); #1;
    Inst_Req_Valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (aq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    check("drain", {16'(aq.size()), 16'(rq.size())}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, dh, fh, b0, t;
    repeat (3) @(negedge clk);
    rst = 0; w_rst = 0;
    @(negedge clk);
    check("reset_state", {Inst_Req_Ready, Mem_Req_Ready, Inst_Valid, Read_data_Valid, mem_ren, mem_wen, mem_busy_cnt},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0});

    issue_f(32'hC, 32'h3C010001, hs);
    drain();
    check("fetch_valid_one_cycle", Inst_Valid, 0);

    Read_data_Ready = 0;
    b0 = mem_busy_cnt;
    issue_d(1, 0, 32'h13, 0, 0, 32'hDEADBEEF, hs);
    for (int i = 0; i < 20 && cyc < hs + 8; i++) @(negedge clk);
    check("bp_valid_held", Read_data_Valid, 1);
    Read_data_Ready = 1;
    @(negedge clk);
    check("bp_valid_drop", Read_data_Valid, 0);
    check("bp_busy_cnt", mem_busy_cnt - b0, 8);

    issue_d(0, 1, 32'h21, 32'h0000AB00, 4'b0010, 0, hs);
    @(negedge clk);
    check("store_ready_low", Mem_Req_Ready, 0);
    @(negedge clk);
    check("store_ready_back", Mem_Req_Ready, 1);
    issue_d(1, 0, 32'h20, 0, 0, 32'h1122AB44, hs);
    drain();

    fork
      issue_d(1, 0, 32'h24, 0, 0, 32'h0BADF00D, dh);
      issue_f(32'hC, 32'h3C010001, fh);
    join
    check("data_priority_gap", fh - dh, 4);
    drain();

    issue_d(1, 1, 32'h28, 32'hCAFEF00D, 4'hF, 0, hs);
    issue_d(1, 0, 32'hFFFC0028, 0, 0, 32'hCAFEF00D, hs);
    drain();

    @(negedge clk);
    w_pc = 32'h14; w_ivalid = 1;
    #1;
    hs = cyc;
    check("w_fetch_accept", w_irr, 1);
    @(posedge clk); #1;
    w_ivalid = 0;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin @(negedge clk); if (w_ren) t = cyc; end
    check("w_ren_cycle", {32'(t), w_mem_addr}, {32'(hs + 4), 16'h5});
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin @(negedge clk); if (w_iv) t = cyc; end
    check("w_valid_cycle", {32'(t), w_inst}, {32'(hs + 6), 32'hA5A50005});

    @(negedge clk);
    @(negedge clk);
    w_addr = 32'h40; w_mw = 1;
    #1;
    check("w_store_accept", w_mrr, 1);
    @(posedge clk); #1;
    w_mw = 0;
    @(negedge clk);
    w_rst = 1;
    repeat (2) @(negedge clk);
    w_rst = 0;
    @(negedge clk);
    check("w_reset_state", {w_irr, w_mrr, w_iv, w_rv, w_busy}, {1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
    repeat (8) @(negedge clk);
    check("w_no_write", w_wen_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
